ssp_rx_deframer: RTL and testbench

- PCLK-domain receive deframer for the SSP frame format generated by the transceiver's transmit side.
- Frame format: SSPFSS high for one serial clock, then 8 data bits, MSB first, on the following 8 serial clocks.
- Synchronizes raw SSPCLKIN/SSPFSSIN/SSPRXD into PCLK, edge-detects the serial clock, deserializes bytes and buffers them in a small show-ahead FIFO with a valid/read handshake.
- Sits between the SSP pins and the receive-side consumer; replaces sampling on the asynchronous SSPCLKIN.

---
 rtl/ssp_rx_deframer.sv | 172 +++++++++++++++++
 tb/tb_ssp_rx_deframer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssp_rx_deframer.sv
// rtl/ssp_rx_deframer.sv - PCLK-domain SSP receive deframer with show-ahead byte FIFO
module ssp_rx_deframer #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          PCLK,
  input  logic                          CLEAR,
  input  logic                          SSPCLKIN,
  input  logic                          SSPFSSIN,
  input  logic                          SSPRXD,
  input  logic                          rx_read,
  input  logic                          ovr_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          overrun,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] fss_sync;
  logic [SYNC_STAGES-1:0] rxd_sync;
  logic                   clk_d;
  logic                   sync_clk;
  logic                   sync_fss;
  logic                   sync_rxd;
  logic                   clk_rise;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic [7:0] shreg;
  logic [7:0] shreg_nxt;
  logic       push;
  logic [7:0] push_byte;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        do_pop;
  logic        do_push;

  // Input synchronizers; the serial clock gets one extra flop for edge detection.
  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      clk_sync <= '0;
      fss_sync <= '0;
      rxd_sync <= '0;
      clk_d    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], SSPCLKIN};
      fss_sync <= {fss_sync[SYNC_STAGES-2:0], SSPFSSIN};
      rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], SSPRXD};
      clk_d    <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign sync_clk = clk_sync[SYNC_STAGES-1];
  assign sync_fss = fss_sync[SYNC_STAGES-1];
  assign sync_rxd = rxd_sync[SYNC_STAGES-1];
  assign clk_rise = sync_clk & ~clk_d;

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state <= IDLE;
      cnt   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Left shift fills MSB first; after eight shifts every bit is fresh, so no clear needed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    if (clk_rise) begin
      case (state)
        IDLE: begin
          if (sync_fss) begin
            state_nxt = SHIFT;
            cnt_nxt   = 3'd0;
          end
        end
        SHIFT: begin
          if (sync_fss) begin
            cnt_nxt = 3'd0;
          end else begin
            shreg_nxt = {shreg[6:0], sync_rxd};
            if (cnt == 3'd7) begin
              state_nxt = IDLE;
              cnt_nxt   = 3'd0;
            end else begin
              cnt_nxt = cnt + 3'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    push      = 1'b0;
    frame_err = 1'b0;
    if (clk_rise && state == SHIFT) begin
      if (sync_fss) begin
        frame_err = (cnt != 3'd0);
      end else begin
        push = (cnt == 3'd7);
      end
    end
  end

  assign push_byte = {shreg[6:0], sync_rxd};

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = rx_read & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge PCLK) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_byte;
    end
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_level <= '0;
      overrun  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ONE;
      end
      case ({do_push, do_pop})
        2'b10:   rx_level <= rx_level + ONE;
        2'b01:   rx_level <= rx_level - ONE;
        default: rx_level <= rx_level;
      endcase
      if (push && !do_push) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign rx_valid = ~empty;
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ssp_rx_deframer.sv
// tb/tb_ssp_rx_deframer.sv - self-checking bench for ssp_rx_deframer
module tb_ssp_rx_deframer;

  localparam int DEPTH = 4;

  logic       PCLK = 1'b0;
  logic       CLEAR;
  logic       SSPCLKIN;
  logic       SSPFSSIN;
  logic       SSPRXD;
  logic       rx_read;
  logic       ovr_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_level;
  logic       overrun;
  logic       frame_err;

  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int fe_high   = 0;
  int fe_pulses = 0;
  bit fe_prev   = 1'b0;

  logic [7:0] model_q[$];
  bit         model_ovr;

  ssp_rx_deframer #(.SYNC_STAGES(2), .FIFO_DEPTH(DEPTH)) dut (
    .PCLK      (PCLK),
    .CLEAR     (CLEAR),
    .SSPCLKIN  (SSPCLKIN),
    .SSPFSSIN  (SSPFSSIN),
    .SSPRXD    (SSPRXD),
    .rx_read   (rx_read),
    .ovr_clr   (ovr_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_level  (rx_level),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (frame_err === 1'b1) begin
      fe_high++;
      if (!fe_prev) fe_pulses++;
    end
    fe_prev = (frame_err === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr = 1'b1;
  endtask

  task automatic pulse_read();
    rx_read = 1'b1;
    idle(1);
    rx_read = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  // Serial clock period is 8 PCLK; data/FSS change while SSPCLKIN is low.
  // With rd_at_sample, rx_read is high on the PCLK edge where the byte is written.
  task automatic serial_bit(input logic fss, input logic d, input bit rd_at_sample);
    SSPFSSIN = fss;
    SSPRXD   = d;
    idle(4);
    SSPCLKIN = 1'b1;
    if (rd_at_sample) begin
      idle(2);
      rx_read = 1'b1;
      idle(1);
      rx_read = 1'b0;
      idle(1);
    end else begin
      idle(4);
    end
    SSPCLKIN = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit rd_last);
    serial_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 7; i >= 0; i--) serial_bit(1'b0, b[i], rd_last && (i == 0));
    SSPFSSIN = 1'b0;
  endtask

  task automatic test_reset();
    CLEAR = 1'b1; SSPCLKIN = 1'b0; SSPFSSIN = 1'b0; SSPRXD = 1'b0;
    rx_read = 1'b0; ovr_clr = 1'b0;
    model_q.delete(); model_ovr = 1'b0;
    idle(3);
    CLEAR = 1'b0;
    idle(1);
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", rx_level); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      SSPRXD = 1'($urandom_range(0, 1));
      SSPCLKIN = ~SSPCLKIN;
      idle(4);
    end
    SSPCLKIN = 1'b0;
    idle(4);
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_level !== 3'd0) $display("FAIL idle_level: got %0d expected 0", rx_level); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL idle_overrun: got %b expected 0", overrun); else pass_cnt++;
    chk_cnt++; if (fe_high !== 0) $display("FAIL idle_frame_err: got %0d high cycles expected 0", fe_high); else pass_cnt++;
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b0);
    model_push(8'hA5);
    idle(2);
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'hA5) $display("FAIL single_data: got %h expected a5", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_level !== 3'd1) $display("FAIL single_level: got %0d expected 1", rx_level); else pass_cnt++;
    pulse_read();
    idle(1);
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL single_pop_valid: got %b expected 0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    vals = '{8'h01, 8'h80, 8'hFF, 8'h3C};
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 4; k++) begin
        send_frame(vals[k], 1'b0);
        model_push(vals[k]);
      end
      idle(2);
      chk_cnt++; if (rx_level !== 3'd4) $display("FAIL b2b_level: rep %0d got %0d expected 4", rep, rx_level); else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
        chk_cnt++; if (rx_data !== vals[k]) $display("FAIL b2b_data: rep %0d idx %0d got %h expected %h", rep, k, rx_data, vals[k]); else pass_cnt++;
        pulse_read();
      end
      idle(1);
      chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL b2b_drained: rep %0d got %b expected 0", rep, rx_valid); else pass_cnt++;
    end
  endtask

  task automatic test_overrun();
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h10 + 8'(k), 1'b0);
      model_push(8'h10 + 8'(k));
    end
    idle(2);
    chk_cnt++; if (rx_level !== 3'd4) $display("FAIL ovr_level: got %0d expected 4", rx_level); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", overrun); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++; if (rx_data !== 8'h10 + 8'(k)) $display("FAIL ovr_data: idx %0d got %h expected %h", k, rx_data, 8'h10 + 8'(k)); else pass_cnt++;
      pulse_read();
    end
    chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", overrun); else pass_cnt++;
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    model_ovr = 1'b0;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h10 + 8'(k), 1'b0);
      model_push(8'h10 + 8'(k));
    end
    send_frame(8'h14, 1'b1);
    void'(model_q.pop_front());
    model_push(8'h14);
    idle(2);
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_pushpop_flag: got %b expected 0", overrun); else pass_cnt++;
    chk_cnt++; if (rx_level !== 3'd4) $display("FAIL ovr_pushpop_level: got %0d expected 4", rx_level); else pass_cnt++;
    for (int k = 1; k < 5; k++) begin
      chk_cnt++; if (rx_data !== 8'h10 + 8'(k)) $display("FAIL ovr_pushpop_data: idx %0d got %h expected %h", k, rx_data, 8'h10 + 8'(k)); else pass_cnt++;
      pulse_read();
    end
  endtask

  task automatic test_abort();
    int p0;
    int h0;
    p0 = fe_pulses;
    h0 = fe_high;
    serial_bit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) serial_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    send_frame(8'h5A, 1'b0);
    model_push(8'h5A);
    idle(2);
    chk_cnt++; if (fe_pulses - p0 !== 1) $display("FAIL abort_pulses: got %0d expected 1", fe_pulses - p0); else pass_cnt++;
    chk_cnt++; if (fe_high - h0 !== 1) $display("FAIL abort_width: got %0d expected 1", fe_high - h0); else pass_cnt++;
    chk_cnt++; if (rx_level !== 3'd1) $display("FAIL abort_level: got %0d expected 1", rx_level); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h5A) $display("FAIL abort_data: got %h expected 5a", rx_data); else pass_cnt++;
    pulse_read();
  endtask

  task automatic test_clear();
    logic [7:0] c3;
    c3 = 8'hC3;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send_frame(b, 1'b0);
      model_push(b);
    end
    serial_bit(1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 4; i--) serial_bit(1'b0, c3[i], 1'b0);
    CLEAR = 1'b1;
    #1;
    model_q.delete();
    model_ovr = 1'b0;
    chk_cnt++; if (rx_level !== 3'd0) $display("FAIL clear_level: got %0d expected 0", rx_level); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL clear_valid: got %b expected 0", rx_valid); else pass_cnt++;
    SSPFSSIN = 1'b0;
    idle(2);
    CLEAR = 1'b0;
    idle(2);
    send_frame(8'h77, 1'b0);
    model_push(8'h77);
    idle(2);
    chk_cnt++; if (rx_level !== 3'd1) $display("FAIL clear_next_level: got %0d expected 1", rx_level); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h77) $display("FAIL clear_next_data: got %h expected 77", rx_data); else pass_cnt++;
    pulse_read();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        logic [7:0] b;
        b = 8'($urandom);
        send_frame(b, 1'b0);
        model_push(b);
      end else if (op <= 4) begin
        pulse_read();
      end else begin
        ovr_clr = 1'b1;
        idle(1);
        ovr_clr = 1'b0;
        model_ovr = 1'b0;
      end
      idle(2);
      chk_cnt++; if (rx_level !== 3'(model_q.size())) $display("FAIL rand_level: it %0d got %0d expected %0d", it, rx_level, model_q.size()); else pass_cnt++;
      chk_cnt++; if (overrun !== model_ovr) $display("FAIL rand_overrun: it %0d got %b expected %b", it, overrun, model_ovr); else pass_cnt++;
      if (model_q.size() > 0) begin
        chk_cnt++; if (rx_data !== model_q[0]) $display("FAIL rand_data: it %0d got %h expected %h", it, rx_data, model_q[0]); else pass_cnt++;
      end else begin
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL rand_valid: it %0d got %b expected 0", it, rx_valid); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
